// File: rtl/spi_master_ctrl.sv
// SPI initiator for the SPI-to-RAM link.
// Serialises host command words and captures read bytes.
module spi_master_ctrl #(
  parameter int RX_DATA_WIDTH = 10,
  parameter int TX_DATA_WIDTH = 8,
  parameter int RD_WAIT       = 2,
  parameter int GAP           = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [RX_DATA_WIDTH-1:0] cmd_word,
  output logic                     rsp_valid,
  output logic [TX_DATA_WIDTH-1:0] rsp_data,
  output logic                     busy,
  output logic                     MOSI,
  output logic                     SS_n,
  input  logic                     MISO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } state_t;

  localparam logic [3:0] ShiftLd = 4'(RX_DATA_WIDTH - 1);
  localparam logic [3:0] WaitLd  = 4'(RD_WAIT - 1);
  localparam logic [3:0] RecvLd  = 4'(TX_DATA_WIDTH - 1);
  localparam logic [3:0] GapLd   = 4'(GAP - 1);

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [RX_DATA_WIDTH-1:0] sh_q, sh_d;
  logic                     rd_q, rd_d;
  logic [TX_DATA_WIDTH-1:0] rx_q, rx_d;
  logic [TX_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     mosi_q, mosi_d;
  logic                     ssn_q, ssn_d;
  logic                     rdy_q, rdy_d;

  assign cmd_ready = rdy_q;
  assign busy      = ~rdy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign MOSI      = mosi_q;
  assign SS_n      = ssn_q;

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    rd_d        = rd_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    mosi_d      = 1'b0;
    ssn_d       = ssn_q;
    rdy_d       = rdy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && rdy_q) begin
          state_d = ST_CMD;
          sh_d    = cmd_word;
          rd_d    = &cmd_word[RX_DATA_WIDTH-1 -: 2];
          mosi_d  = cmd_word[RX_DATA_WIDTH-1];
          ssn_d   = 1'b0;
          rdy_d   = 1'b0;
        end
      end
      ST_CMD: begin
        state_d = ST_SHIFT;
        cnt_d   = ShiftLd;
        mosi_d  = sh_q[RX_DATA_WIDTH-1];
        sh_d    = sh_q << 1;
      end
      ST_SHIFT: begin
        if (cnt_q == 4'd0) begin
          if (rd_q) begin
            state_d = ST_WAIT;
            cnt_d   = WaitLd;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GapLd;
            ssn_d   = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          mosi_d = sh_q[RX_DATA_WIDTH-1];
          sh_d   = sh_q << 1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RECV;
          cnt_d   = RecvLd;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECV: begin
        rx_d = (rx_q << 1) | {{(TX_DATA_WIDTH-1){1'b0}}, MISO};
        if (cnt_q == 4'd0) begin
          state_d     = ST_GAP;
          cnt_d       = GapLd;
          ssn_d       = 1'b1;
          rsp_data_d  = rx_d;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ssn_d   = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      rd_q        <= 1'b0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      mosi_q      <= 1'b0;
      ssn_q       <= 1'b1;
      rdy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      rd_q        <= rd_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      mosi_q      <= mosi_d;
      ssn_q       <= ssn_d;
      rdy_q       <= rdy_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: default and RD_WAIT=4/GAP=3 instances,
// checked against a frame-level model and a small slave RAM.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       t_valid;
  logic       sel;
  logic [9:0] cmd_word;
  logic       MISO;

  logic       d1_ready, d1_rv, d1_busy, d1_mosi, d1_ss;
  logic [7:0] d1_rd;
  logic       d2_ready, d2_rv, d2_busy, d2_mosi, d2_ss;
  logic [7:0] d2_rd;

  logic       s_ready, s_rv, s_busy, s_mosi, s_ss;
  logic [7:0] s_rd;

  int tests = 0;
  int fails = 0;

  bit [7:0] ram [256];
  bit [7:0] wa, ra;
  logic [7:0] exp_rsp [2];

  always #5 clk = ~clk;

  spi_master_ctrl u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(t_valid & ~sel), .cmd_ready(d1_ready),
    .cmd_word(cmd_word),
    .rsp_valid(d1_rv), .rsp_data(d1_rd), .busy(d1_busy),
    .MOSI(d1_mosi), .SS_n(d1_ss), .MISO(MISO)
  );

  spi_master_ctrl #(.RD_WAIT(4), .GAP(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(t_valid & sel), .cmd_ready(d2_ready),
    .cmd_word(cmd_word),
    .rsp_valid(d2_rv), .rsp_data(d2_rd), .busy(d2_busy),
    .MOSI(d2_mosi), .SS_n(d2_ss), .MISO(MISO)
  );

  always_comb begin
    s_ready = sel ? d2_ready : d1_ready;
    s_rv    = sel ? d2_rv    : d1_rv;
    s_busy  = sel ? d2_busy  : d1_busy;
    s_mosi  = sel ? d2_mosi  : d1_mosi;
    s_ss    = sel ? d2_ss    : d1_ss;
    s_rd    = sel ? d2_rd    : d1_rd;
  end

  task automatic chk(input string tag, input logic [39:0] obs,
                     input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command through the selected instance, checked frame-wide.
  task automatic do_cmd(input logic [9:0] w);
    int n, low, g, rw, gp, elen, early, bad;
    logic [39:0] got, expv;
    logic [7:0] rb;
    logic [1:0] op;
    op = w[9:8];
    rw = sel ? 4 : 2;
    gp = sel ? 3 : 1;
    elen = (op == 2'b11) ? 19 + rw : 11;
    rb = 8'h00;
    case (op)
      2'b00: wa = w[7:0];
      2'b01: ram[wa] = w[7:0];
      2'b10: ra = w[7:0];
      default: rb = ram[ra];
    endcase
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", 40'(n < 200), 40'd1);
    t_valid = 1'b1;
    cmd_word = w;
    tick();
    t_valid = 1'b0;
    cmd_word = 10'($urandom);
    chk("busy_on_accept", 40'(s_busy), 40'd1);
    chk("ready_on_accept", 40'(s_ready), 40'd0);
    low = 0;
    early = 0;
    got = '0;
    while (s_ss === 1'b0 && low < 40) begin
      got[low] = s_mosi;
      if (op == 2'b11 && low >= 11 + rw && low < 19 + rw)
        MISO = rb[18 + rw - low];
      else
        MISO = 1'($urandom);
      if (s_rv !== 1'b0) early++;
      tick();
      low++;
    end
    chk("frame_len", 40'(low), 40'(elen));
    expv = '0;
    for (int i = 0; i <= 10; i++)
      expv[i] = (i == 0) ? w[9] : w[10 - i];
    chk("mosi_seq", got, expv);
    chk("rsp_early", 40'(early), 40'd0);
    if (op == 2'b11) exp_rsp[sel] = rb;
    chk("rsp_valid", 40'(s_rv), 40'(op == 2'b11));
    chk("rsp_data", 40'(s_rd), 40'(exp_rsp[sel]));
    g = 0;
    bad = 0;
    while (s_busy === 1'b1 && g < 40) begin
      if (s_ss !== 1'b1 || s_mosi !== 1'b0) bad++;
      if (g > 0 && s_rv !== 1'b0) bad++;
      tick();
      g++;
    end
    chk("gap_len", 40'(g), 40'(gp));
    chk("gap_lines", 40'(bad), 40'd0);
    chk("ready_after_gap", 40'(s_ready), 40'd1);
    chk("rsp_hold", 40'(s_rd), 40'(exp_rsp[sel]));
  endtask

  function automatic int spacing(input logic [9:0] w);
    return ((w[9:8] == 2'b11) ? 21 : 11) + 1 + 1;
  endfunction

  initial begin
    logic [9:0] ws [4];
    int k, cyc, last, frames, bad;
    logic rdy, prev_ss;
    rst_n = 1'b0;
    t_valid = 1'b0;
    sel = 1'b0;
    cmd_word = '0;
    MISO = 1'b0;
    exp_rsp[0] = 8'h00;
    exp_rsp[1] = 8'h00;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_ss", 40'(d1_ss), 40'd1);
    chk("rst_mosi", 40'(d1_mosi), 40'd0);
    chk("rst_ready", 40'(d1_ready), 40'd1);
    chk("rst_busy", 40'(d1_busy), 40'd0);
    chk("rst_rv", 40'(d1_rv), 40'd0);
    chk("rst_rd", 40'(d1_rd), 40'd0);

    do_cmd(10'h0A5);
    do_cmd(10'h13C);
    chk("ram_a5", 40'(ram[8'hA5]), 40'h3C);
    do_cmd(10'h2A5);
    do_cmd(10'h300);
    chk("readback", 40'(d1_rd), 40'h3C);

    do_cmd(10'h010);
    do_cmd(10'h181);
    do_cmd(10'h210);
    do_cmd(10'h300);
    chk("miso_order", 40'(d1_rd), 40'h81);
    do_cmd(10'h0C3);
    chk("rsp_hold_81", 40'(d1_rd), 40'h81);

    for (int i = 0; i < 16; i++) do_cmd(10'($urandom));

    cmd_word = 10'h1FF;
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    repeat (5) tick();
    chk("mid_frame_active", 40'(d1_ss), 40'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ss", 40'(d1_ss), 40'd1);
    chk("arst_mosi", 40'(d1_mosi), 40'd0);
    chk("arst_ready", 40'(d1_ready), 40'd1);
    chk("arst_busy", 40'(d1_busy), 40'd0);
    chk("arst_rv", 40'(d1_rv), 40'd0);
    exp_rsp[0] = 8'h00;
    exp_rsp[1] = 8'h00;
    @(posedge clk);
    #4 rst_n = 1'b1;
    tick();
    chk("post_rst_rv", 40'(d1_rv), 40'd0);
    do_cmd(10'h0F0);

    ws[0] = 10'h0A5;
    ws[1] = 10'h300;
    ws[2] = 10'h13C;
    ws[3] = 10'h2A5;
    MISO = 1'b0;
    k = 0;
    cyc = 0;
    last = 0;
    frames = 0;
    bad = 0;
    prev_ss = d1_ss;
    cmd_word = ws[0];
    t_valid = 1'b1;
    while (k < 4 && cyc < 400) begin
      rdy = s_ready;
      tick();
      cyc++;
      if (s_ss === 1'b0 && prev_ss === 1'b1) frames++;
      prev_ss = s_ss;
      if (s_busy === s_ready) bad++;
      if (rdy === 1'b1) begin
        if (k > 0)
          chk("accept_spacing", 40'(cyc - last), 40'(spacing(ws[k-1])));
        last = cyc;
        k++;
        if (k < 4) cmd_word = ws[k];
      end
    end
    t_valid = 1'b0;
    chk("stress_accepts", 40'(k), 40'd4);
    repeat (40) begin
      tick();
      if (s_ss === 1'b0 && prev_ss === 1'b1) frames++;
      prev_ss = s_ss;
      if (s_busy === s_ready) bad++;
    end
    chk("stress_frames", 40'(frames), 40'd4);
    chk("stress_busy", 40'(bad), 40'd0);
    chk("stress_idle", 40'(s_ready), 40'd1);
    chk("stress_rsp", 40'(d1_rd), 40'd0);

    sel = 1'b1;
    do_cmd(10'h033);
    do_cmd(10'h1C7);
    do_cmd(10'h233);
    do_cmd(10'h300);
    chk("p2_readback", 40'(d2_rd), 40'hC7);
    for (int i = 0; i < 4; i++) do_cmd(10'($urandom));
    do_cmd(10'h3AA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Initiator end of the team's 4-wire SPI-to-RAM link. It turns parallel command words from a host into SPI frames on SS_n/MOSI.
- For read-data commands, it captures the returned byte from MISO and hands it back to the host.
- Runs on the same clk as the slave/RAM subsystem. Registered outputs connect straight to that subsystem's MOSI, SS_n and MISO.

Parameters:
- RX_DATA_WIDTH, 10, width of command word sent to slave; bits [9:8] = opcode, [7:0] = address/data.
- TX_DATA_WIDTH, 8, width of read byte returned on MISO.
- RD_WAIT, 2, idle cycles (SS_n held low) between last MOSI bit and first MISO sample on read-data frames; legal 1..15.
- GAP, 1, cycles SS_n held high after every frame before the next frame may start; legal 1..15.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- cmd_valid, input, 1, host presents cmd_word.
- cmd_ready, output, 1, block can accept a command.
- cmd_word, input, RX_DATA_WIDTH, opcode + payload. Opcodes: 00 write addr, 01 write data, 10 read addr, 11 read data.
- rsp_valid, output, 1, one-cycle pulse; rsp_data valid.
- rsp_data, output, TX_DATA_WIDTH, byte captured from MISO; holds until the next capture.
- busy, output, 1, high from accept until the end of GAP.
- MOSI, output, 1, serial data to slave.
- SS_n, output, 1, active-low slave select.
- MISO, input, 1, serial data from slave.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; SS_n=1, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0; shift register and counters cleared.
  - Reset mid-frame aborts immediately: SS_n goes high with the reset, and no rsp_valid is produced.
- Accept:
  - Occurs on a clk edge with cmd_valid && cmd_ready. cmd_word is latched into the shift register.
  - cmd_ready drops and busy rises at that same edge.
  - cmd_valid while cmd_ready=0 is ignored; the host must hold it.
- FSM states: IDLE, CMD, SHIFT, WAIT, RECV, GAP.
  - IDLE -> CMD on accept.
  - CMD (1 cycle): SS_n=0, MOSI=cmd_word[9] (0 = write-type, 1 = read-type).
  - SHIFT (RX_DATA_WIDTH cycles): MOSI = cmd_word[9] down to [0], MSB first, one bit per cycle; SS_n=0.
  - After SHIFT:
    - opcode 11 -> WAIT.
    - all other opcodes -> GAP.
  - WAIT (RD_WAIT cycles): SS_n=0, MOSI=0.
  - RECV (TX_DATA_WIDTH cycles): SS_n=0, MOSI=0. MISO is sampled at the end of each cycle, MSB first, into a receive shift register.
  - After the 8th sample:
    - rsp_data updates and rsp_valid=1 for exactly one cycle, coinciding with the first GAP cycle.
    - The state moves to GAP.
  - GAP (GAP cycles): SS_n=1, MOSI=0.
  - After GAP: cmd_ready=1 and busy=0, both in the same cycle -> IDLE.
- Frame lengths (SS_n low):
  - Write/read-addr frames: 1+RX_DATA_WIDTH = 11 cycles.
  - Read-data frames: 11+RD_WAIT+TX_DATA_WIDTH = 21 cycles at defaults.
- Throughput:
  - Minimum accept-to-accept spacing = frame length + GAP + 1.
  - Back-to-back commands never merge; SS_n is always high for at least GAP cycles between frames.
- MOSI changes only on clk edges. MISO is treated as synchronous to clk (same-clock slave), so no synchronizer is used.
- Opcode is taken only from the latched cmd_word; changes on the cmd_word input after accept have no effect.
- Counters: 4-bit bit counter shared by SHIFT/WAIT/RECV/GAP, reloaded on each state entry. No wrap beyond the terminal count.
- The block does not track the address/read sequence. Issuing 11 without a prior 10 is legal; the captured byte is whatever MISO carries.

Test Plan:
- Reset mid-frame: assert rst_n=0 during SHIFT bit 4 -> SS_n=1, MOSI=0, cmd_ready=1 immediately. No rsp_valid. The next command produces a clean 11-cycle frame.
- Write sequence: cmd_word=0x0A5 (opcode 00, addr 0xA5), then 0x13C (opcode 01, data 0x3C) -> two 11-cycle SS_n-low frames. MOSI serial = 0,0010100101 then 0,0100111100. GAP of 1 high cycle between frames. Slave RAM location 0xA5 reads 0x3C.
- Read-back: after the write above, cmd_word=0x2A5 then 0x300 -> second frame is 21 cycles low. rsp_valid pulses once with rsp_data=0x3C in the first cycle after SS_n rises.
- MISO bit order: model drives MISO=1,0,0,0,0,0,0,1 during RECV of an opcode-11 frame -> rsp_data=0x81. rsp_data holds 0x81 through a following 00 command.
- Handshake stress: hold cmd_valid=1 continuously with 4 words -> exactly 4 accepts, each only when cmd_ready=1. busy=1 between accepts. SS_n high for ≥1 cycle between frames.
- Parameter check: RD_WAIT=4, GAP=3 -> read-data frame low for 23 cycles; SS_n high for 3 cycles before cmd_ready returns.
